// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WN    = 16;
    localparam int WD    = 8;
    localparam int CNT_W = $clog2(WN);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract D.
module div_step #(
    parameter int WD = 8
) (
    input  logic [WD:0]   rem,
    input  logic          din,
    input  logic [WD-1:0] d,
    output logic [WD:0]   rem_next,
    output logic          qbit
);

    logic [WD:0] t_s;
    logic [WD:0] d_ext_s;
    logic        ge_s;

    // Trial subtraction; a set top bit of rem already implies the shifted value exceeds D.
    always_comb begin
        t_s      = {rem[WD-1:0], din};
        d_ext_s  = {1'b0, d};
        ge_s     = rem[WD] | (t_s >= d_ext_s);
        rem_next = t_s;
        qbit     = 1'b0;
        if (ge_s) begin
            rem_next = t_s - d_ext_s;
            qbit     = 1'b1;
        end else begin
            rem_next = t_s;
            qbit     = 1'b0;
        end
    end

endmodule

// File: rtl/seq_div_16_8.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_div_16_8
    import seq_div_pkg::*;
#(
    parameter int WN = seq_div_pkg::WN,
    parameter int WD = seq_div_pkg::WD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WN-1:0] IN1,
    input  logic [WD-1:0] IN2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WN-1:0] Q,
    output logic [WD-1:0] R,
    output logic          div0
);

    localparam int CW = $clog2(WN);

    state_t        state_r;
    logic [WD:0]   rem_r;
    logic [WN-1:0] qsr_r;
    logic [WD-1:0] d_r;
    logic [CW-1:0] cnt_r;

    logic [WD:0]   step_rem_s;
    logic          step_q_s;

    div_step #(
        .WD (WD)
    ) u_step (
        .rem      (rem_r),
        .din      (qsr_r[WN-1]),
        .d        (d_r),
        .rem_next (step_rem_s),
        .qbit     (step_q_s)
    );

    // Control FSM, iteration counter, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            rem_r     <= {(WD+1){1'b0}};
            qsr_r     <= {WN{1'b0}};
            d_r       <= {WD{1'b0}};
            cnt_r     <= {CW{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Q         <= {WN{1'b0}};
            R         <= {WD{1'b0}};
            div0      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (IN2 != {WD{1'b0}}) begin
                            d_r     <= IN2;
                            qsr_r   <= IN1;
                            rem_r   <= {(WD+1){1'b0}};
                            cnt_r   <= CW'(WN - 1);
                            state_r <= BUSY;
                        end else begin
                            // Divide by zero resolves immediately without iterating.
                            Q         <= {WN{1'b1}};
                            R         <= IN1[WD-1:0];
                            div0      <= 1'b1;
                            out_valid <= 1'b1;
                            state_r   <= DONE;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    rem_r <= step_rem_s;
                    qsr_r <= {qsr_r[WN-2:0], step_q_s};
                    if (cnt_r == {CW{1'b0}}) begin
                        Q         <= {qsr_r[WN-2:0], step_q_s};
                        R         <= step_rem_s[WD-1:0];
                        div0      <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_16_8.sv
// Randomised self-checking bench for seq_div_16_8 against a plain-arithmetic division model.
module tb_seq_div_16_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] IN1;
    logic [7:0]  IN2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        div0;

    int checks = 0;
    int errors = 0;

    seq_div_16_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .IN1       (IN1),
        .IN2       (IN2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction: offer operands, wait for the result, hold it for 'stall' cycles, then take it.
    task automatic run_op(input logic [15:0] n, input logic [7:0] d, input int stall);
        logic [15:0] q_exp;
        logic [7:0]  r_exp;
        logic [15:0] q_held;
        logic [7:0]  r_held;
        int          cycles;
        int          lat_exp;
        if (d == 8'd0) begin
            q_exp   = 16'hFFFF;
            r_exp   = n[7:0];
            lat_exp = 0;
        end else begin
            q_exp   = n / {8'd0, d};
            r_exp   = 8'(n % {8'd0, d});
            lat_exp = 16;
        end
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        IN1      = n;
        IN2      = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        IN1      = 16'($urandom);
        IN2      = 8'($urandom);
        cycles   = 0;
        while (!out_valid && cycles < 40) begin
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("latency", cycles, lat_exp);
        chk("quotient", {16'd0, Q}, {16'd0, q_exp});
        chk("remainder", {24'd0, R}, {24'd0, r_exp});
        chk("div0", {31'd0, div0}, {31'd0, (d == 8'd0)});
        if (d != 8'd0) begin
            chk("identity", 32'(Q) * 32'(d) + 32'(R), {16'd0, n});
            chk("r_lt_d", {31'd0, (R < d)}, 32'd1);
        end
        q_held = Q;
        r_held = R;
        for (int i = 0; i < stall; i++) begin
            in_valid  = 1'b1;
            IN1       = 16'($urandom);
            IN2       = 8'($urandom_range(1, 255));
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_q", {16'd0, Q}, {16'd0, q_held});
            chk("stall_r", {24'd0, R}, {24'd0, r_held});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int        seen_valid;
        logic [7:0] rd;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        IN1       = 16'd0;
        IN2       = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_q", {16'd0, Q}, 32'd0);
        chk("rst_r", {24'd0, R}, 32'd0);
        chk("rst_div0", {31'd0, div0}, 32'd0);

        // Directed cases, then backpressure.
        run_op(16'd1000, 8'd7, 0);
        run_op(16'hFFFF, 8'hFF, 0);
        run_op(16'hFFFF, 8'd1, 0);
        run_op(16'd5, 8'd9, 0);
        run_op(16'd0, 8'd37, 0);
        run_op(16'd200, 8'd0, 0);
        run_op(16'd1000, 8'd7, 5);

        // Reset in the middle of an operation discards it.
        in_valid = 1'b1;
        IN1      = 16'h1234;
        IN2      = 8'h56;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_q", {16'd0, Q}, 32'd0);
        chk("midrst_r", {24'd0, R}, 32'd0);
        chk("midrst_div0", {31'd0, div0}, 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        chk("midrst_no_result", seen_valid, 32'd0);
        run_op(16'h1234, 8'h56, 0);

        // Every divisor against the largest dividend.
        for (int d = 0; d < 256; d++) begin
            run_op(16'hFFFF, 8'(d), 0);
        end

        // Random operands with occasional backpressure.
        for (int k = 0; k < 2000; k++) begin
            case ($urandom_range(0, 3))
                0:       rd = 8'd0;
                1:       rd = 8'($urandom_range(1, 15));
                default: rd = 8'($urandom);
            endcase
            run_op(($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                   rd, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
